// File: rtl/irrigation_pkg.sv
// Shared encodings for the soil-moisture classifier and the irrigation pump controller.
package irrigation_pkg;

  localparam logic [1:0] CLS_DRY = 2'b00;
  localparam logic [1:0] CLS_OPT = 2'b01;
  localparam logic [1:0] CLS_WET = 2'b10;
  localparam logic [1:0] CLS_INV = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WATER = 2'b01;
  localparam logic [1:0] ST_SOAK  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/class_debouncer.sv
// Accepts a soil class once DEBOUNCE_N consecutive identical valid samples are seen.
module class_debouncer
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] soil_class,
  input  logic       sample_valid,
  output logic [1:0] stable_class,
  output logic       stable_valid
);

  localparam logic [3:0] CNT_N = 4'(DEBOUNCE_N);

  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] stable_class_q, stable_class_d;
  logic       stable_valid_q, stable_valid_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    cand_d         = cand_q;
    cnt_d          = cnt_q;
    stable_class_d = stable_class_q;
    stable_valid_d = stable_valid_q;
    if (sample_valid) begin
      if (soil_class == CLS_INV) begin
        cnt_d = 4'd0;
      end else begin
        if (soil_class == cand_q) begin
          if (cnt_q < CNT_N) cnt_d = cnt_q + 4'd1;
        end else begin
          cand_d = soil_class;
          cnt_d  = 4'd1;
        end
        // Re-accepting an already stable class is harmless, so a level test suffices.
        if (cnt_d == CNT_N) begin
          stable_class_d = cand_d;
          stable_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      cand_q         <= CLS_DRY;
      cnt_q          <= 4'd0;
      stable_class_q <= CLS_DRY;
      stable_valid_q <= 1'b0;
    end else begin
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      stable_class_q <= stable_class_d;
      stable_valid_q <= stable_valid_d;
    end
  end

  assign stable_class = stable_class_q;
  assign stable_valid = stable_valid_q;

endmodule

// File: rtl/irrigation_pump_controller.sv
// Watering FSM: debounced soil class drives the pump with min-on, max-run fault and soak lockout.
module irrigation_pump_controller
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_N    = 4,
  parameter int MIN_ON_CYCLES = 1000,
  parameter int MAX_ON_CYCLES = 100000,
  parameter int SOAK_CYCLES   = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  soil_class,
  input  logic        sample_valid,
  input  logic        enable,
  input  logic        fault_clr,
  output logic        pump_on,
  output logic [1:0]  state,
  output logic        fault,
  output logic [1:0]  stable_class,
  output logic        stable_valid,
  output logic [15:0] water_count
);

  localparam int ON_W   = clog2(MAX_ON_CYCLES);
  localparam int SOAK_W = clog2(SOAK_CYCLES);

  localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(MAX_ON_CYCLES - 1);
  localparam logic [ON_W-1:0]   ON_MIN    = ON_W'(MIN_ON_CYCLES - 1);
  localparam logic [SOAK_W-1:0] SOAK_LAST = SOAK_W'(SOAK_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [ON_W-1:0]   on_timer_q, on_timer_d;
  logic [SOAK_W-1:0] soak_timer_q, soak_timer_d;
  logic [15:0]       water_count_q, water_count_d;

  class_debouncer #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_debouncer (
    .clk         (clk),
    .rst_n       (rst_n),
    .soil_class  (soil_class),
    .sample_valid(sample_valid),
    .stable_class(stable_class),
    .stable_valid(stable_valid)
  );

  always_comb begin
    state_d       = state_q;
    on_timer_d    = on_timer_q;
    soak_timer_d  = soak_timer_q;
    water_count_d = water_count_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && stable_valid && stable_class == CLS_DRY) begin
          state_d    = ST_WATER;
          on_timer_d = '0;
          if (water_count_q != 16'hFFFF) water_count_d = water_count_q + 16'd1;
        end
      end
      ST_WATER: begin
        on_timer_d = on_timer_q + 1'b1;
        // The run-time limit outranks both an enable drop and a normal stop.
        if (on_timer_q == ON_LAST) begin
          state_d = ST_FAULT;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end else if (on_timer_q >= ON_MIN && stable_class != CLS_DRY) begin
          state_d      = ST_SOAK;
          soak_timer_d = '0;
        end
      end
      ST_SOAK: begin
        if (!enable || soak_timer_q == SOAK_LAST) begin
          state_d = ST_IDLE;
        end else begin
          soak_timer_d = soak_timer_q + 1'b1;
        end
      end
      default: begin
        if (fault_clr) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      on_timer_q    <= '0;
      soak_timer_q  <= '0;
      water_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      on_timer_q    <= on_timer_d;
      soak_timer_q  <= soak_timer_d;
      water_count_q <= water_count_d;
    end
  end

  assign state       = state_q;
  assign pump_on     = (state_q == ST_WATER);
  assign fault       = (state_q == ST_FAULT);
  assign water_count = water_count_q;

endmodule

// File: tb/tb_irrigation_pump_controller.sv
// Directed bench for the irrigation pump controller with small timing parameters.
module tb_irrigation_pump_controller;
  import irrigation_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  soil_class;
  logic        sample_valid;
  logic        enable;
  logic        fault_clr;
  logic        pump_on;
  logic [1:0]  state;
  logic        fault;
  logic [1:0]  stable_class;
  logic        stable_valid;
  logic [15:0] water_count;

  int total;
  int bad;

  irrigation_pump_controller #(
    .DEBOUNCE_N   (3),
    .MIN_ON_CYCLES(8),
    .MAX_ON_CYCLES(20),
    .SOAK_CYCLES  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .soil_class  (soil_class),
    .sample_valid(sample_valid),
    .enable      (enable),
    .fault_clr   (fault_clr),
    .pump_on     (pump_on),
    .state       (state),
    .fault       (fault),
    .stable_class(stable_class),
    .stable_valid(stable_valid),
    .water_count (water_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] cls);
    soil_class   = cls;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic apply_reset();
    enable       = 1'b0;
    fault_clr    = 1'b0;
    sample_valid = 1'b0;
    soil_class   = CLS_DRY;
    rst_n        = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic enter_water();
    enable = 1'b1;
    send(CLS_DRY);
    send(CLS_DRY);
    send(CLS_DRY);
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({state, pump_on, fault, stable_class, stable_valid, water_count} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs: got st=%0d pump=%0b flt=%0b cls=%0d sv=%0b wc=%0d expected all zero",
               state, pump_on, fault, stable_class, stable_valid, water_count);
    end
  endtask

  task automatic test_basic_start();
    apply_reset();
    enable = 1'b1;
    send(CLS_DRY);
    send(CLS_DRY);
    send(CLS_DRY);
    total++;
    if (stable_class !== CLS_DRY || stable_valid !== 1'b1 || state !== ST_IDLE) begin
      bad++;
      $display("FAIL accept_e3: got cls=%0d sv=%0b st=%0d expected cls=0 sv=1 st=0",
               stable_class, stable_valid, state);
    end
    step();
    total++;
    if (state !== ST_WATER || pump_on !== 1'b1 || water_count !== 16'd1) begin
      bad++;
      $display("FAIL water_e4: got st=%0d pump=%0b wc=%0d expected st=1 pump=1 wc=1",
               state, pump_on, water_count);
    end
  endtask

  task automatic test_interrupted_debounce();
    apply_reset();
    enable = 1'b1;
    send(CLS_DRY);
    send(CLS_DRY);
    send(CLS_OPT);
    send(CLS_DRY);
    send(CLS_DRY);
    step();
    total++;
    if (stable_valid !== 1'b0 || pump_on !== 1'b0 || state !== ST_IDLE) begin
      bad++;
      $display("FAIL broken_run: got sv=%0b pump=%0b st=%0d expected sv=0 pump=0 st=0",
               stable_valid, pump_on, state);
    end
  endtask

  task automatic test_min_on_soak();
    int n;
    int m;
    apply_reset();
    enter_water();
    n = 0;
    if (pump_on) n++;
    send(CLS_OPT);
    if (pump_on) n++;
    send(CLS_OPT);
    if (pump_on) n++;
    send(CLS_OPT);
    if (pump_on) n++;
    total++;
    if (stable_class !== CLS_OPT) begin
      bad++;
      $display("FAIL opt_accept: got cls=%0d expected 1", stable_class);
    end
    for (int i = 0; i < 50 && pump_on; i++) begin
      step();
      if (pump_on) n++;
    end
    total++;
    if (n !== 8 || state !== ST_SOAK) begin
      bad++;
      $display("FAIL min_on_len: got cycles=%0d st=%0d expected cycles=8 st=2", n, state);
    end
    m = 0;
    for (int i = 0; i < 50 && state == ST_SOAK; i++) begin
      m++;
      step();
    end
    total++;
    if (m !== 5 || state !== ST_IDLE || pump_on !== 1'b0) begin
      bad++;
      $display("FAIL soak_len: got cycles=%0d st=%0d pump=%0b expected cycles=5 st=0 pump=0",
               m, state, pump_on);
    end
    send(CLS_DRY);
    send(CLS_DRY);
    send(CLS_DRY);
    step();
    total++;
    if (state !== ST_WATER || water_count !== 16'd2) begin
      bad++;
      $display("FAIL rewater: got st=%0d wc=%0d expected st=1 wc=2", state, water_count);
    end
  endtask

  task automatic test_max_fault();
    int n;
    apply_reset();
    enter_water();
    n = 0;
    if (pump_on) n++;
    for (int i = 0; i < 100 && pump_on; i++) begin
      step();
      if (pump_on) n++;
    end
    total++;
    if (n !== 20 || state !== ST_FAULT || fault !== 1'b1 || pump_on !== 1'b0) begin
      bad++;
      $display("FAIL max_run: got cycles=%0d st=%0d flt=%0b pump=%0b expected cycles=20 st=3 flt=1 pump=0",
               n, state, fault, pump_on);
    end
    send(CLS_DRY);
    send(CLS_DRY);
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    total++;
    if (state !== ST_FAULT || fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_sticky: got st=%0d flt=%0b expected st=3 flt=1", state, fault);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    total++;
    if (state !== ST_IDLE || fault !== 1'b0) begin
      bad++;
      $display("FAIL fault_clr: got st=%0d flt=%0b expected st=0 flt=0", state, fault);
    end
    step();
    total++;
    if (state !== ST_WATER || water_count !== 16'd2) begin
      bad++;
      $display("FAIL post_clr_water: got st=%0d wc=%0d expected st=1 wc=2", state, water_count);
    end
  endtask

  task automatic test_max_priority();
    apply_reset();
    enter_water();
    repeat (19) step();
    total++;
    if (state !== ST_WATER) begin
      bad++;
      $display("FAIL pre_limit: got st=%0d expected 1", state);
    end
    enable = 1'b0;
    step();
    total++;
    if (state !== ST_FAULT) begin
      bad++;
      $display("FAIL limit_beats_enable: got st=%0d expected 3", state);
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    enter_water();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    total++;
    if (state !== ST_WATER) begin
      bad++;
      $display("FAIL clr_ignored: got st=%0d expected 1", state);
    end
    enable = 1'b0;
    step();
    total++;
    if (state !== ST_IDLE || pump_on !== 1'b0 || water_count !== 16'd1) begin
      bad++;
      $display("FAIL enable_drop: got st=%0d pump=%0b wc=%0d expected st=0 pump=0 wc=1",
               state, pump_on, water_count);
    end
  endtask

  task automatic test_invalid_class();
    apply_reset();
    send(CLS_WET);
    send(CLS_WET);
    send(CLS_WET);
    total++;
    if (stable_class !== CLS_WET || stable_valid !== 1'b1) begin
      bad++;
      $display("FAIL wet_accept: got cls=%0d sv=%0b expected cls=2 sv=1", stable_class, stable_valid);
    end
    send(CLS_DRY);
    send(CLS_INV);
    total++;
    if (stable_class !== CLS_WET) begin
      bad++;
      $display("FAIL inv_keeps: got cls=%0d expected 2", stable_class);
    end
    send(CLS_DRY);
    send(CLS_DRY);
    total++;
    if (stable_class !== CLS_WET) begin
      bad++;
      $display("FAIL inv_restart: got cls=%0d expected 2", stable_class);
    end
    send(CLS_DRY);
    total++;
    if (stable_class !== CLS_DRY) begin
      bad++;
      $display("FAIL inv_third: got cls=%0d expected 0", stable_class);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    enter_water();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pump_on !== 1'b0 || state !== ST_IDLE) begin
      bad++;
      $display("FAIL async_drop: got pump=%0b st=%0d expected pump=0 st=0", pump_on, state);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    total++;
    if ({state, pump_on, fault, stable_class, stable_valid, water_count} !== 23'd0) begin
      bad++;
      $display("FAIL after_reset: got st=%0d pump=%0b flt=%0b cls=%0d sv=%0b wc=%0d expected all zero",
               state, pump_on, fault, stable_class, stable_valid, water_count);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    fault_clr    = 1'b0;
    sample_valid = 1'b0;
    soil_class   = CLS_DRY;
    test_reset();
    test_basic_start();
    test_interrupted_debounce();
    test_min_on_soak();
    test_max_fault();
    test_max_priority();
    test_enable_drop();
    test_invalid_class();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
